mult_div_unit: RTL and testbench

- Iterative multi-cycle multiply/divide unit with architectural HI/LO registers.
- Executes the mult, multu, div, divu operations that ALU control decodes (function codes 24-27).
- Also services mthi/mtlo writes.
- Sits beside the ALU in the execute stage; the control FSM stalls on busy and reads hi/lo for mfhi/mflo.

---
 rtl/mult_div_unit.sv | 165 ++++++++++++++++
 tb/tb_mult_div_unit.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - iterative multiply/divide unit with HI/LO registers
// Optional single-cycle multiplier: MULDIV_FAST_MULT_EN
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             hi_wr,
    input  logic             lo_wr,
    input  logic [WIDTH-1:0] wr_data,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIX, S_DONE} state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    logic               is_div_q, is_div_d;
    logic               neg_res_q, neg_res_d;
    logic               neg_rem_q, neg_rem_d;
    logic               dbz_q, dbz_d;
    logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;

    logic               signed_op, idle_like, last_iter, div_ge;
    logic [WIDTH-1:0]   a_mag, b_mag, div_diff, fix_quo, fix_rem;
    logic [WIDTH:0]     rem_sh;
    logic [2*WIDTH-1:0] fix_prod;

    assign signed_op = ~op[0];
    assign idle_like = (state_q == S_IDLE) || (state_q == S_DONE);
    assign a_mag     = (signed_op && a[WIDTH-1]) ? (~a + WIDTH'(1)) : a;
    assign b_mag     = (signed_op && b[WIDTH-1]) ? (~b + WIDTH'(1)) : b;
    assign last_iter = (cnt_q == CW'(WIDTH - 1));

    // acc holds {partial remainder, remaining dividend / quotient bits} during DIV
    assign rem_sh   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    assign div_ge   = (rem_sh >= {1'b0, opnd_q});
    assign div_diff = rem_sh[WIDTH-1:0] - opnd_q;

    assign fix_prod = neg_res_q ? (~acc_q + (2*WIDTH)'(1)) : acc_q;
    assign fix_quo  = neg_res_q ? (~acc_q[WIDTH-1:0] + WIDTH'(1)) : acc_q[WIDTH-1:0];
    assign fix_rem  = neg_rem_q ? (~acc_q[2*WIDTH-1:WIDTH] + WIDTH'(1)) : acc_q[2*WIDTH-1:WIDTH];

`ifdef MULDIV_FAST_MULT_EN
    logic [2*WIDTH-1:0] fast_prod;
    assign fast_prod = {{WIDTH{1'b0}}, opnd_q} * {{WIDTH{1'b0}}, acc_q[WIDTH-1:0]};
`else
    logic [WIDTH:0] mul_sum;
    assign mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        opnd_d    = opnd_q;
        is_div_d  = is_div_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        dbz_d     = dbz_q;
        hi_d      = hi_q;
        lo_d      = lo_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                dbz_d   = 1'b0;
                if (start) begin
                    cnt_d     = '0;
                    is_div_d  = op[1];
                    neg_res_d = signed_op && (a[WIDTH-1] ^ b[WIDTH-1]);
                    neg_rem_d = signed_op && a[WIDTH-1];
                    if (!op[1]) begin
                        acc_d   = {{WIDTH{1'b0}}, b_mag};
                        opnd_d  = a_mag;
                        state_d = S_MUL;
                    end else if (b == '0) begin
                        dbz_d   = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        acc_d   = {{WIDTH{1'b0}}, a_mag};
                        opnd_d  = b_mag;
                        state_d = S_DIV;
                    end
                end
            end
            S_MUL: begin
`ifdef MULDIV_FAST_MULT_EN
                {hi_d, lo_d} = neg_res_q ? (~fast_prod + (2*WIDTH)'(1)) : fast_prod;
                state_d      = S_DONE;
`else
                acc_d = {mul_sum, acc_q[WIDTH-1:1]};
                cnt_d = cnt_q + CW'(1);
                if (last_iter) state_d = S_FIX;
`endif
            end
            S_DIV: begin
                acc_d = div_ge ? {div_diff, acc_q[WIDTH-2:0], 1'b1}
                               : {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
                cnt_d = cnt_q + CW'(1);
                if (last_iter) state_d = S_FIX;
            end
            S_FIX: begin
                if (is_div_q) begin
                    lo_d = fix_quo;
                    hi_d = fix_rem;
                end else begin
                    {hi_d, lo_d} = fix_prod;
                end
                cnt_d   = '0;
                state_d = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase

        // Register writes land after any result so a DONE-cycle write wins
        if (idle_like) begin
            if (hi_wr) hi_d = wr_data;
            if (lo_wr) lo_d = wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            opnd_q    <= '0;
            is_div_q  <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            dbz_q     <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            opnd_q    <= opnd_d;
            is_div_q  <= is_div_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            dbz_q     <= dbz_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

    assign busy        = (state_q == S_MUL) || (state_q == S_DIV) || (state_q == S_FIX);
    assign done        = (state_q == S_DONE);
    assign div_by_zero = (state_q == S_DONE) && dbz_q;
    assign hi          = hi_q;
    assign lo          = lo_q;
endmodule

// File: tb/tb_mult_div_unit.sv
// tb/tb_mult_div_unit.sv - self-checking bench for mult_div_unit against an arithmetic model
module tb_mult_div_unit;
    localparam int W = 32;
`ifdef MULDIV_FAST_MULT_EN
    localparam int MUL_LAT = 2;
`else
    localparam int MUL_LAT = W + 2;
`endif

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [1:0]   op;
    logic [W-1:0] a, b, wr_data;
    logic         hi_wr, lo_wr;
    logic         busy, done, div_by_zero;
    logic [W-1:0] hi, lo;

    int errors = 0;
    int checks = 0;
    logic [W-1:0] hi_m = '0;
    logic [W-1:0] lo_m = '0;

    mult_div_unit #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
        .hi_wr(hi_wr), .lo_wr(lo_wr), .wr_data(wr_data),
        .busy(busy), .done(done), .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int exp_lat(input logic [1:0] o, input logic [W-1:0] y);
        if (!o[1]) return MUL_LAT;
        if (y == 0) return 1;
        return W + 2;
    endfunction

    // Reference: plain 64-bit arithmetic; SV division truncates toward zero
    task automatic model_op(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        longint sx, sy, q, r;
        logic [63:0] p;
        case (o)
            2'd0: begin
                p = longint'($signed(x)) * longint'($signed(y));
                {hi_m, lo_m} = p;
            end
            2'd1: begin
                p = {32'd0, x} * {32'd0, y};
                {hi_m, lo_m} = p;
            end
            default: begin
                if (y != 0) begin
                    if (o == 2'd2) begin
                        sx = longint'($signed(x));
                        sy = longint'($signed(y));
                    end else begin
                        sx = longint'({32'd0, x});
                        sy = longint'({32'd0, y});
                    end
                    q = sx / sy;
                    r = sx % sy;
                    lo_m = q[W-1:0];
                    hi_m = r[W-1:0];
                end
            end
        endcase
    endtask

    task automatic write_reg(input logic hw, input logic lw, input logic [W-1:0] d);
        hi_wr = hw; lo_wr = lw; wr_data = d;
        @(posedge clk);
        @(negedge clk);
        hi_wr = 1'b0; lo_wr = 1'b0;
        if (hw) hi_m = d;
        if (lw) lo_m = d;
    endtask

    // Called at a negedge with the unit idle or in DONE; returns at the done-cycle negedge
    task automatic run_op(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                          input logic hw, input logic lw, input logic [W-1:0] wd, input int inject);
        int n, busy_cnt, lat;
        start = 1'b1; op = o; a = x; b = y;
        hi_wr = hw; lo_wr = lw; wr_data = wd;
        if (hw) hi_m = wd;
        if (lw) lo_m = wd;
        model_op(o, x, y);
        lat = exp_lat(o, y);
        @(posedge clk);
        @(negedge clk);
        start = 1'b0; hi_wr = 1'b0; lo_wr = 1'b0;
        n = 1;
        busy_cnt = 0;
        while (!done && n < 100) begin
            if (busy) busy_cnt++;
            start = (n == inject);
            lo_wr = (n == inject);
            if (n == inject) begin
                op = 2'($urandom_range(0, 3)); a = $urandom; b = $urandom; wr_data = 32'hDEADBEEF;
            end
            @(posedge clk);
            @(negedge clk);
            n++;
        end
        start = 1'b0; lo_wr = 1'b0;
        check_eq("latency", 64'(n), 64'(lat));
        check_eq("busy_cycles", 64'(busy_cnt), 64'(lat - 1));
        check_eq("busy_at_done", 64'(busy), 64'd0);
        check_eq("div_by_zero", 64'(div_by_zero), 64'(o[1] && (y == 0)));
        check_eq("hi", 64'(hi), 64'(hi_m));
        check_eq("lo", 64'(lo), 64'(lo_m));
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 5))
            0:       return '0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return W'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int done_cnt, lat, inj;
        logic [1:0] ro;
        logic [W-1:0] ra, rb;
        rst_n = 1'b0; start = 1'b0; op = '0; a = '0; b = '0;
        hi_wr = 1'b0; lo_wr = 1'b0; wr_data = '0;
        repeat (2) @(negedge clk);
        check_eq("rst_busy", 64'(busy), 64'd0);
        check_eq("rst_done", 64'(done), 64'd0);
        check_eq("rst_dbz", 64'(div_by_zero), 64'd0);
        check_eq("rst_hi", 64'(hi), 64'd0);
        check_eq("rst_lo", 64'(lo), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        run_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, '0, 0);
        check_eq("tp_multu_hi", 64'(hi), 64'hFFFF_FFFE);
        check_eq("tp_multu_lo", 64'(lo), 64'h0000_0001);
        run_op(2'd0, 32'hFFFF_FFFD, 32'd7, 1'b0, 1'b0, '0, 0);
        check_eq("tp_mult_hi", 64'(hi), 64'hFFFF_FFFF);
        check_eq("tp_mult_lo", 64'(lo), 64'hFFFF_FFEB);
        run_op(2'd3, 32'd100, 32'd7, 1'b0, 1'b0, '0, 0);
        check_eq("tp_divu_lo", 64'(lo), 64'd14);
        check_eq("tp_divu_hi", 64'(hi), 64'd2);
        run_op(2'd2, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0, '0, 0);
        check_eq("tp_div_lo", 64'(lo), 64'hFFFF_FFFD);
        check_eq("tp_div_hi", 64'(hi), 64'hFFFF_FFFF);
        run_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, '0, 0);
        check_eq("tp_ovf_lo", 64'(lo), 64'h8000_0000);
        check_eq("tp_ovf_hi", 64'(hi), 64'd0);
        write_reg(1'b1, 1'b0, 32'h1234_5678);
        write_reg(1'b0, 1'b1, 32'h0);
        run_op(2'd3, 32'd5, 32'd0, 1'b0, 1'b0, '0, 0);
        check_eq("tp_dbz_hi", 64'(hi), 64'h1234_5678);
        check_eq("tp_dbz_lo", 64'(lo), 64'd0);
        run_op(2'd0, 32'h0001_2345, 32'hFFFF_FF00, 1'b0, 1'b0, '0, (MUL_LAT > 5) ? 5 : 0);

        // Reset during a divide: everything clears at once and no done follows
        @(negedge clk);
        start = 1'b1; op = 2'd2; a = 32'd1000; b = 32'd3;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (9) begin
            @(posedge clk);
            @(negedge clk);
        end
        rst_n = 1'b0;
        #1;
        check_eq("midrst_busy", 64'(busy), 64'd0);
        check_eq("midrst_done", 64'(done), 64'd0);
        check_eq("midrst_hi", 64'(hi), 64'd0);
        check_eq("midrst_lo", 64'(lo), 64'd0);
        hi_m = '0; lo_m = '0;
        @(negedge clk);
        rst_n = 1'b1;
        done_cnt = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) done_cnt++;
        end
        check_eq("midrst_no_done", 64'(done_cnt), 64'd0);

        for (int i = 0; i < 40; i++) begin
            ro = 2'($urandom_range(0, 3));
            ra = pick();
            rb = pick();
            lat = exp_lat(ro, rb);
            inj = (lat > 5 && $urandom_range(0, 3) == 0) ? int'($urandom_range(1, lat - 1)) : 0;
            if ($urandom_range(0, 2) == 0) @(negedge clk);
            run_op(ro, ra, rb, 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) == 0),
                   $urandom, inj);
            if ($urandom_range(0, 3) == 0) begin
                write_reg(1'b1, 1'($urandom_range(0, 1)), $urandom);
                check_eq("done_wr_hi", 64'(hi), 64'(hi_m));
                check_eq("done_wr_lo", 64'(lo), 64'(lo_m));
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
